// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit.
// Contents: operand width default, op-code constants, FSM state type and a
// helper that tells signed ops apart from unsigned ones.
package muldiv_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  function automatic logic op_is_signed(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_hilo_unit_abs_neg.sv
// abs_neg: conditional two's-complement negation.
// Ports:
//   in_val  - value to pass through or negate
//   neg     - 1 selects the negated value
//   out_val - result (purely combinational)
// Used both for taking operand magnitudes and for restoring result signs.
module abs_neg #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] in_val,
  input  logic             neg,
  output logic [WIDTH-1:0] out_val
);

  assign out_val = neg ? ({WIDTH{1'b0}} - in_val) : in_val;

endmodule

// File: rtl/muldiv_hilo_unit.sv
// muldiv_hilo_unit: iterative HI/LO multiply/divide unit for the EX stage.
// Ports:
//   Clk, Reset     - clock, asynchronous active-high reset
//   Start, Op      - request strobe and operation (MULT/MULTU/DIV/DIVU/MTHI/MTLO)
//   A, B           - rs / rt operands
//   Busy           - high while a multi-cycle operation is running
//   Done           - one-cycle pulse when a request completes
//   DivByZero      - sticky divide-by-zero flag, cleared by the next accepted Start
//   HI, LO         - architectural HI/LO registers
// Multiply and divide take 32 RUN iterations on magnitudes, then one FIX
// cycle that restores signs and writes HI/LO.
module muldiv_hilo_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 6
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  state_e state_q, state_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;
  logic             is_div_q, is_div_d;
  logic             neg_hi_q, neg_hi_d;
  logic             neg_lo_q, neg_lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opb_q, opb_d;       // multiplicand or divisor magnitude
  logic [WIDTH:0]   work_hi_q, work_hi_d; // product high half / partial remainder
  logic [WIDTH-1:0] work_lo_q, work_lo_d; // multiplier bits / dividend-quotient bits

  logic             accept;
  logic             arith_op;
  logic             div_op;
  logic             div_zero;
  logic             sign_a;
  logic             sign_b;
  logic             last_iter;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH+1:0] rem_shift;
  logic [WIDTH+1:0] rem_diff;

  assign accept    = Start && (state_q == ST_IDLE);
  assign arith_op  = (Op <= OP_DIVU);
  assign div_op    = (Op == OP_DIV) || (Op == OP_DIVU);
  assign div_zero  = div_op && (B == '0);
  assign sign_a    = op_is_signed(Op) && A[WIDTH-1];
  assign sign_b    = op_is_signed(Op) && B[WIDTH-1];
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

  // Operand magnitudes. |0x80000000| wraps to itself, which read as unsigned
  // is the correct magnitude, so the most-negative operand needs no special case.
  abs_neg #(.WIDTH(WIDTH)) u_abs_a (.in_val(A), .neg(sign_a), .out_val(mag_a));
  abs_neg #(.WIDTH(WIDTH)) u_abs_b (.in_val(B), .neg(sign_b), .out_val(mag_b));

  // Sign restoration applied in FIX.
  abs_neg #(.WIDTH(2*WIDTH)) u_fix_prod (
    .in_val ({work_hi_q[WIDTH-1:0], work_lo_q}),
    .neg    (neg_lo_q),
    .out_val(prod_fix)
  );
  abs_neg #(.WIDTH(WIDTH)) u_fix_quo (
    .in_val (work_lo_q),
    .neg    (neg_lo_q),
    .out_val(quo_fix)
  );
  abs_neg #(.WIDTH(WIDTH)) u_fix_rem (
    .in_val (work_hi_q[WIDTH-1:0]),
    .neg    (neg_hi_q),
    .out_val(rem_fix)
  );

  // State register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
      is_div_q  <= 1'b0;
      neg_hi_q  <= 1'b0;
      neg_lo_q  <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      opb_q     <= '0;
      work_hi_q <= '0;
      work_lo_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
      is_div_q  <= is_div_d;
      neg_hi_q  <= neg_hi_d;
      neg_lo_q  <= neg_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      opb_q     <= opb_d;
      work_hi_q <= work_hi_d;
      work_lo_q <= work_lo_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept && arith_op && !div_zero) state_d = ST_RUN;
      ST_RUN:  if (last_iter) state_d = ST_FIX;
      ST_FIX:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and output register updates
  always_comb begin
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dbz_d     = dbz_q;
    is_div_d  = is_div_q;
    neg_hi_d  = neg_hi_q;
    neg_lo_d  = neg_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    opb_d     = opb_q;
    work_hi_d = work_hi_q;
    work_lo_d = work_lo_q;

    // Multiply step: add multiplicand when the multiplier LSB is set, then
    // shift the whole {work_hi, work_lo} pair right by one.
    mul_sum   = work_hi_q + (work_lo_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
    // Divide step: shift the next dividend bit into the partial remainder and
    // trial-subtract; the extra top bit of rem_diff is the borrow.
    rem_shift = {work_hi_q, work_lo_q[WIDTH-1]};
    rem_diff  = rem_shift - {2'b00, opb_q};

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          dbz_d = 1'b0;
          if (Op == OP_MTHI) begin
            hi_d   = A;
            done_d = 1'b1;
          end else if (Op == OP_MTLO) begin
            lo_d   = A;
            done_d = 1'b1;
          end else if (arith_op) begin
            if (div_zero) begin
              dbz_d  = 1'b1;
              done_d = 1'b1;
            end else begin
              busy_d    = 1'b1;
              cnt_d     = '0;
              is_div_d  = div_op;
              opb_d     = mag_b;
              work_hi_d = '0;
              work_lo_d = mag_a;
              neg_lo_d  = sign_a ^ sign_b;
              // Remainder takes the dividend's sign; product uses one sign for both halves.
              neg_hi_d  = div_op ? sign_a : (sign_a ^ sign_b);
            end
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (is_div_q) begin
          if (!rem_diff[WIDTH+1]) begin
            work_hi_d = rem_diff[WIDTH:0];
            work_lo_d = {work_lo_q[WIDTH-2:0], 1'b1};
          end else begin
            work_hi_d = rem_shift[WIDTH:0];
            work_lo_d = {work_lo_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          work_hi_d = {1'b0, mul_sum[WIDTH:1]};
          work_lo_d = {mul_sum[0], work_lo_q[WIDTH-1:1]};
        end
      end
      ST_FIX: begin
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        done_d = 1'b1;
        busy_d = 1'b0;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  assign Busy      = busy_q;
  assign Done      = done_q;
  assign DivByZero = dbz_q;
  assign HI        = hi_q;
  assign LO        = lo_q;

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Scoreboard bench for muldiv_hilo_unit: stimulus pushes expected HI/LO,
// DivByZero and Busy-cycle count; a monitor pops and compares on every Done.
module tb_muldiv_hilo_unit;
  import muldiv_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic [2:0]  Op;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic        Done;
  logic        DivByZero;
  logic [31:0] HI;
  logic [31:0] LO;

  muldiv_hilo_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Start    (Start),
    .Op       (Op),
    .A        (A),
    .B        (B),
    .Busy     (Busy),
    .Done     (Done),
    .DivByZero(DivByZero),
    .HI       (HI),
    .LO       (LO)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          busy;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks   = 0;
  int   errors   = 0;
  int   busy_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Monitor: count Busy cycles, compare against the scoreboard on Done.
  initial begin
    forever begin
      @(negedge Clk);
      if (Reset) begin
        busy_cnt = 0;
      end else begin
        if (Busy) busy_cnt++;
        if (Done) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done actual=Done expected=no Done HI=%h LO=%h", HI, LO);
          end else begin
            mon_e = sb.pop_front();
            chk({mon_e.name, "_hi"}, HI, mon_e.hi);
            chk({mon_e.name, "_lo"}, LO, mon_e.lo);
            chk({mon_e.name, "_dbz"}, {31'd0, DivByZero}, {31'd0, mon_e.dbz});
            chk_int({mon_e.name, "_busy_cycles"}, busy_cnt, mon_e.busy);
          end
          busy_cnt = 0;
        end
      end
    end
  end

  // Drives a request for exactly one rising edge; caller positions it away from posedge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit push, input string name, input logic [31:0] ehi,
                       input logic [31:0] elo, input logic edbz, input int ebusy);
    exp_t e;
    Start = 1'b1;
    Op    = op;
    A     = a;
    B     = b;
    if (push) begin
      e.name = name;
      e.hi   = ehi;
      e.lo   = elo;
      e.dbz  = edbz;
      e.busy = ebusy;
      sb.push_back(e);
    end
    @(posedge Clk);
    #1 Start = 1'b0;
  endtask

  // Counts falling edges until Done; leaves the caller at the Done-cycle negedge.
  task automatic wait_done(input string name, input int exp_lat);
    int  n;
    bit  seen;
    n    = 0;
    seen = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge Clk);
      if (Done) begin
        n    = i;
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=no Done in 100 cycles expected=Done after %0d", name, exp_lat);
    end else begin
      chk_int({name, "_latency"}, n, exp_lat);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=time limit reached expected=bench completion");
    $fatal(1);
  end

  initial begin
    Reset = 1'b1;
    Start = 1'b0;
    Op    = 3'd0;
    A     = '0;
    B     = '0;
    repeat (2) @(negedge Clk);
    chk("reset_hi", HI, 32'h0);
    chk("reset_lo", LO, 32'h0);
    chk("reset_busy", {31'd0, Busy}, 32'h0);
    chk("reset_done", {31'd0, Done}, 32'h0);
    chk("reset_dbz", {31'd0, DivByZero}, 32'h0);
    Reset = 1'b0;
    @(negedge Clk);

    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, "multu_max", 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33);
    wait_done("multu_max", 34);

    issue(OP_MULT, 32'hFFFF_FFFD, 32'd7, 1, "mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 33);
    wait_done("mult_neg", 34);

    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1, "div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33);
    wait_done("div_neg", 34);

    issue(OP_DIVU, 32'd100, 32'd7, 1, "divu_100_7", 32'd2, 32'd14, 1'b0, 33);
    wait_done("divu_100_7", 34);

    issue(OP_DIV, 32'd5, 32'd0, 1, "div_zero", 32'd2, 32'd14, 1'b1, 0);
    wait_done("div_zero", 1);

    issue(OP_MTLO, 32'h0000_1234, 32'd0, 1, "mtlo", 32'd2, 32'h0000_1234, 1'b0, 0);
    wait_done("mtlo", 1);

    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1, "div_wrap", 32'h0, 32'h8000_0000, 1'b0, 33);
    wait_done("div_wrap", 34);

    issue(3'd7, 32'h0000_0055, 32'h0000_0066, 1, "reserved", 32'h0, 32'h8000_0000, 1'b0, 0);
    wait_done("reserved", 1);

    issue(OP_MTHI, 32'h0000_CAFE, 32'd0, 1, "mthi", 32'h0000_CAFE, 32'h8000_0000, 1'b0, 0);
    wait_done("mthi", 1);

    // MTHI request while busy must be dropped.
    issue(OP_MULT, 32'd6, 32'd7, 1, "mult_ignore", 32'h0, 32'd42, 1'b0, 33);
    repeat (9) @(negedge Clk);
    Start = 1'b1;
    Op    = OP_MTHI;
    A     = 32'hDEAD_BEEF;
    @(posedge Clk);
    #1 Start = 1'b0;
    wait_done("mult_ignore", 25);

    // Second request issued in the Done cycle of the first.
    issue(OP_MULTU, 32'd3, 32'd5, 1, "multu_small", 32'h0, 32'd15, 1'b0, 33);
    wait_done("multu_small", 34);
    issue(OP_DIVU, 32'hFFFF_FFFF, 32'h10, 1, "divu_b2b", 32'h0000_000F, 32'h0FFF_FFFF, 1'b0, 33);
    wait_done("divu_b2b", 34);

    // Reset in the middle of a multiply discards it.
    issue(OP_MULT, 32'd2, 32'd3, 0, "", 32'h0, 32'h0, 1'b0, 0);
    repeat (19) @(negedge Clk);
    Reset = 1'b1;
    #1;
    chk("midreset_busy", {31'd0, Busy}, 32'h0);
    chk("midreset_hi", HI, 32'h0);
    chk("midreset_lo", LO, 32'h0);
    chk("midreset_done", {31'd0, Done}, 32'h0);
    @(negedge Clk);
    Reset = 1'b0;
    repeat (40) @(negedge Clk);
    chk("postreset_hi", HI, 32'h0);
    chk("postreset_lo", LO, 32'h0);
    chk("postreset_busy", {31'd0, Busy}, 32'h0);
    chk_int("scoreboard_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
